mem_responder: RTL and testbench

- Synthesizable memory-side responder for the narrow memory request/response interface (lagd_mem_narr_req_t / lagd_mem_narr_rsp_t) driven by axi_to_mem_adapter.
- Accepts word requests, updates or reads an internal word array, and returns responses after a fixed, parameterized latency.
- Replaces ad-hoc response stubs in memory-island benches.
- Also usable as a behavioural SRAM stand-in on the mem port of the memory island.

---
 rtl/mem_responder_pkg.sv | 41 ++++
 rtl/mem_responder_pipe.sv | 46 ++++
 rtl/mem_responder.sv | 136 +++++++++++++
 tb/tb_mem_responder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared constants, default narrow memory request/response types and helpers
// for the mem_responder block.
package mem_responder_pkg;

    localparam int unsigned MemResponderMaxLatency = 32'd8;
    localparam int unsigned LfsrWidth              = 32'd16;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
    localparam logic [15:0] LfsrTaps               = 16'hB400;
    localparam logic [15:0] LfsrDefaultSeed        = 16'hACE1;

    typedef struct packed {
        logic [47:0] addr;
        logic        write;
        logic [63:0] data;
        logic [7:0]  strb;
    } lagd_mem_narr_q_t;

    typedef struct packed {
        logic             q_valid;
        lagd_mem_narr_q_t q;
    } lagd_mem_narr_req_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
    } lagd_mem_narr_p_t;

    typedef struct packed {
        logic             q_ready;
        lagd_mem_narr_p_t p;
    } lagd_mem_narr_rsp_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LfsrTaps)};
    endfunction

    function automatic bit is_pow2(input int unsigned value);
        return (value != 32'd0) && ((value & (value - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/mem_responder_pipe.sv
// Fixed-depth valid/data delay line; every stage advances each cycle and the
// whole line clears on asynchronous reset.
module mem_responder_pipe #(
    parameter int unsigned Latency   = 32'd1,
    parameter int unsigned DataWidth = 32'd64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    input  logic [DataWidth-1:0] in_data_i,
    output logic                 out_valid_o,
    output logic [DataWidth-1:0] out_data_o
);

    logic [Latency-1:0]                valid_q;
    logic [Latency-1:0]                valid_d;
    logic [Latency-1:0][DataWidth-1:0] data_q;
    logic [Latency-1:0][DataWidth-1:0] data_d;

    // Next-stage values: stage 0 takes the new entry, others shift down.
    always_comb begin
        valid_d    = valid_q;
        data_d     = data_q;
        valid_d[0] = in_valid_i;
        data_d[0]  = in_data_i;
        for (int i = 1; i < int'(Latency); i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
        end
    end

    // Delay-line registers, cleared asynchronously so in-flight responses drop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q[Latency-1];
    assign out_data_o  = data_q[Latency-1];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: word array with byte strobes and fixed-latency responses.
// Optional random request stalls are enabled by defining MEM_RESPONDER_STALL_EN.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter type         mem_req_t = lagd_mem_narr_req_t,
    parameter type         mem_rsp_t = lagd_mem_narr_rsp_t,
    parameter int unsigned AddrWidth = 32'd48,
    parameter int unsigned DataWidth = 32'd64,
    parameter int unsigned NumWords  = 32'd2048,
    parameter int unsigned Latency   = 32'd1,
    parameter logic [15:0] StallSeed = LfsrDefaultSeed
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  mem_req_t mem_req_i,
    output mem_rsp_t mem_rsp_o
);

    localparam int unsigned StrbWidth = DataWidth / 32'd8;
    localparam int unsigned OffWidth  = $clog2(StrbWidth);
    localparam int unsigned IdxWidth  = $clog2(NumWords);

    if ((Latency < 32'd1) || (Latency > MemResponderMaxLatency)) begin : g_bad_latency
        $error("mem_responder: Latency must lie in 1..%0d", MemResponderMaxLatency);
    end
    if (!is_pow2(NumWords) || !is_pow2(DataWidth) || (DataWidth < 32'd8)) begin : g_bad_geometry
        $error("mem_responder: NumWords and DataWidth must be powers of two, DataWidth >= 8");
    end
    if (AddrWidth < (IdxWidth + OffWidth)) begin : g_bad_addr
        $error("mem_responder: AddrWidth too narrow for the word index and byte offset");
    end

    logic [DataWidth-1:0] mem_q [NumWords];
    logic [DataWidth-1:0] wr_word_d;
    logic [DataWidth-1:0] rd_word_s;
    logic [DataWidth-1:0] rsp_data_s;
    logic [IdxWidth-1:0]  idx_s;
    logic                 accept_s;
    logic                 ready_q;
    logic                 ready_d;
    logic                 rsp_valid_s;
    logic [DataWidth-1:0] rsp_word_s;
    logic                 unused_addr_s;

    // Upper address bits wrap silently and byte-offset bits are ignored.
    assign idx_s         = mem_req_i.q.addr[OffWidth +: IdxWidth];
    assign unused_addr_s = ^mem_req_i.q.addr;
    assign accept_s      = mem_req_i.q_valid & ready_q;

    // Read the addressed word and build the strobe-merged write word.
    always_comb begin
        rd_word_s = mem_q[idx_s];
        wr_word_d = rd_word_s;
        for (int b = 0; b < int'(StrbWidth); b++) begin
            if (mem_req_i.q.strb[b]) begin
                wr_word_d[8*b +: 8] = mem_req_i.q.data[8*b +: 8];
            end else begin
                wr_word_d[8*b +: 8] = rd_word_s[8*b +: 8];
            end
        end
    end

    // Writes answer with zero data; reads carry the word sampled before the write.
    always_comb begin
        if (accept_s && !mem_req_i.q.write) begin
            rsp_data_s = rd_word_s;
        end else begin
            rsp_data_s = '0;
        end
    end

    // Word storage: deliberately not reset so contents survive a reset pulse.
    always_ff @(posedge clk_i) begin
        if (accept_s && mem_req_i.q.write) begin
            mem_q[idx_s] <= wr_word_d;
        end
    end

`ifdef MEM_RESPONDER_STALL_EN
    logic [LfsrWidth-1:0] lfsr_q;
    logic [LfsrWidth-1:0] lfsr_d;

    // Ready tracks the LFSR state of the coming cycle so it stays a flop output.
    always_comb begin
        lfsr_d  = lfsr_next(lfsr_q);
        ready_d = ~(&lfsr_d[1:0]);
    end

    // Stall generator state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q  <= StallSeed;
            ready_q <= ~(&StallSeed[1:0]);
        end else begin
            lfsr_q  <= lfsr_d;
            ready_q <= ready_d;
        end
    end
`else
    // Without stalls the responder accepts every cycle after reset.
    always_comb begin
        ready_d = 1'b1;
    end

    // Ready register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_q <= 1'b1;
        end else begin
            ready_q <= ready_d;
        end
    end
`endif

    mem_responder_pipe #(
        .Latency   (Latency),
        .DataWidth (DataWidth)
    ) u_pipe (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (accept_s),
        .in_data_i   (rsp_data_s),
        .out_valid_o (rsp_valid_s),
        .out_data_o  (rsp_word_s)
    );

    // Response channel assembled from registered sources only.
    always_comb begin
        mem_rsp_o         = '0;
        mem_rsp_o.q_ready = ready_q;
        mem_rsp_o.p.valid = rsp_valid_s;
        mem_rsp_o.p.data  = rsp_word_s;
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: two responders (Latency 1 and 4) share one request
// stream and are compared against a word-array/history reference model.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int HMAX = 2048;

    logic clk = 1'b0;
    logic rst_n;
    lagd_mem_narr_req_t req;
    lagd_mem_narr_rsp_t rsp1, rsp4;

    always #5 clk = ~clk;

    mem_responder #(.Latency(32'd1)) dut_l1 (
        .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req), .mem_rsp_o(rsp1));
    mem_responder #(.Latency(32'd4)) dut_l4 (
        .clk_i(clk), .rst_ni(rst_n), .mem_req_i(req), .mem_rsp_o(rsp4));

    logic [63:0] ref_mem [2048];
    bit          written [2048];
    bit          hist_v  [HMAX];
    logic [63:0] hist_d  [HMAX];
    logic [63:0] bb_data [8];
    logic [15:0] ref_lfsr;
    bit          ref_ready;
    int          cyc, floor_c;
    int          checks, errors;

    function automatic int widx(input logic [47:0] a);
        return int'((a >> 3) % 48'd2048);
    endfunction

    function automatic bit exp_v(input int lat);
        int j = cyc - lat;
        if (j < floor_c) return 1'b0;
        return hist_v[j];
    endfunction

    function automatic logic [63:0] exp_d(input int lat);
        int j = cyc - lat;
        if (j < floor_c) return 64'd0;
        return hist_d[j];
    endfunction

    task automatic model_reset();
        ref_lfsr  = 16'hACE1;
        floor_c   = cyc;
`ifdef MEM_RESPONDER_STALL_EN
        ref_ready = !(ref_lfsr[1] && ref_lfsr[0]);
`else
        ref_ready = 1'b1;
`endif
    endtask

    // One clock: drive at negedge, update the model at posedge, return at negedge.
    task automatic step(input bit v, input bit w, input logic [47:0] a,
                        input logic [63:0] d, input logic [7:0] s, output bit acc);
        int k;
        req.q_valid = v; req.q.write = w; req.q.addr = a; req.q.data = d; req.q.strb = s;
        @(posedge clk);
        acc = v && ref_ready;
        hist_v[cyc] = acc;
        hist_d[cyc] = 64'd0;
        if (acc) begin
            k = widx(a);
            if (!w) hist_d[cyc] = ref_mem[k];
            else begin
                for (int b = 0; b < 8; b++)
                    if (s[b]) ref_mem[k][8*b +: 8] = d[8*b +: 8];
                if (s == 8'hFF) written[k] = 1'b1;
            end
        end
`ifdef MEM_RESPONDER_STALL_EN
        ref_lfsr  = {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
        ref_ready = !(ref_lfsr[1] && ref_lfsr[0]);
`endif
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 48'd0, 64'd0, 8'd0, acc);
    endtask

    task automatic issue(input bit w, input logic [47:0] a, input logic [63:0] d, input logic [7:0] s);
        bit acc;
        int tries = 0;
        do begin
            step(1'b1, w, a, d, s, acc);
            tries++;
        end while (!acc && tries < 32);
        if (!acc) begin
            checks++; errors++;
            $display("FAIL accept_timeout addr %h: no accept within 32 cycles", a);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = '0;
        cyc   = 0;
        model_reset();
        #12;
        checks++; if (rsp1.p.valid !== 1'b0) begin errors++; $display("FAIL reset_valid_l1 got %b exp 0", rsp1.p.valid); end
        checks++; if (rsp4.p.valid !== 1'b0) begin errors++; $display("FAIL reset_valid_l4 got %b exp 0", rsp4.p.valid); end
        checks++; if (rsp1.p.data !== 64'd0) begin errors++; $display("FAIL reset_data_l1 got %h exp 0", rsp1.p.data); end
        checks++; if (rsp4.p.data !== 64'd0) begin errors++; $display("FAIL reset_data_l4 got %h exp 0", rsp4.p.data); end
        checks++; if (rsp1.q_ready !== ref_ready) begin errors++; $display("FAIL reset_ready got %b exp %b", rsp1.q_ready, ref_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_write_read();
        issue(1'b1, 48'h40, 64'h1122334455667788, 8'hFF);
        issue(1'b0, 48'h40, 64'd0, 8'd0);
        checks++; if (rsp1.p.valid !== 1'b1) begin errors++; $display("FAIL rd_valid_l1 got %b exp 1", rsp1.p.valid); end
        checks++; if (rsp1.p.data !== 64'h1122334455667788) begin errors++; $display("FAIL rd_data_l1 got %h exp 1122334455667788", rsp1.p.data); end
        idle(3);
        checks++; if (rsp4.p.data !== 64'h1122334455667788 || rsp4.p.valid !== 1'b1) begin errors++; $display("FAIL rd_data_l4 got %b/%h exp 1/1122334455667788", rsp4.p.valid, rsp4.p.data); end
        issue(1'b1, 48'h40, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        issue(1'b0, 48'h40, 64'd0, 8'd0);
        checks++; if (rsp1.p.data !== 64'h11223344AAAAAAAA) begin errors++; $display("FAIL strb_data_l1 got %h exp 11223344aaaaaaaa", rsp1.p.data); end
        idle(3);
        checks++; if (rsp4.p.data !== 64'h11223344AAAAAAAA) begin errors++; $display("FAIL strb_data_l4 got %h exp 11223344aaaaaaaa", rsp4.p.data); end
        issue(1'b1, 48'h4000, 64'hDEAD, 8'hFF);
        issue(1'b0, 48'h0, 64'd0, 8'd0);
        checks++; if (rsp1.p.data !== 64'hDEAD) begin errors++; $display("FAIL wrap_data_l1 got %h exp dead", rsp1.p.data); end
        idle(3);
        checks++; if (rsp4.p.data !== 64'hDEAD) begin errors++; $display("FAIL wrap_data_l4 got %h exp dead", rsp4.p.data); end
        issue(1'b1, 48'h48, 64'hBEEF, 8'h03);
        issue(1'b0, 48'h48, 64'd0, 8'd0);
        checks++; if (rsp1.p.data !== exp_d(1)) begin errors++; $display("FAIL raw_data_l1 got %h exp %h", rsp1.p.data, exp_d(1)); end
    endtask

    task automatic test_back_to_back();
        bit acc;
        int first_k = -1, run = 0, seen = 0;
        for (int i = 0; i < 8; i++) begin
            bb_data[i] = {$urandom, $urandom};
            issue(1'b1, 48'h100 + 48'(8 * i), bb_data[i], 8'hFF);
        end
        idle(4);
        for (int k = 0; k < 14; k++) begin
            step(k < 8, 1'b0, 48'h100 + 48'(8 * (k % 8)), 64'd0, 8'd0, acc);
            checks++;
            if (rsp4.p.valid !== exp_v(4)) begin errors++; $display("FAIL b2b_valid_l4 k=%0d got %b exp %b", k, rsp4.p.valid, exp_v(4)); end
            if (rsp4.p.valid === 1'b1) begin
                if (first_k < 0) first_k = k;
                run++;
                checks++;
                if (seen < 8 && rsp4.p.data !== bb_data[seen]) begin errors++; $display("FAIL b2b_order_l4 n=%0d got %h exp %h", seen, rsp4.p.data, bb_data[seen]); end
                seen++;
            end
        end
`ifndef MEM_RESPONDER_STALL_EN
        checks++;
        if (first_k !== 3 || run !== 8) begin errors++; $display("FAIL b2b_window_l4 got start %0d len %0d exp start 3 len 8", first_k, run); end
`endif
    endtask

    task automatic test_reset_inflight();
        bit acc;
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 48'h100 + 48'(8 * k), 64'd0, 8'd0, acc);
        req.q_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (rsp1.p.valid !== 1'b0) begin errors++; $display("FAIL rstflight_valid_l1 got %b exp 0", rsp1.p.valid); end
        checks++; if (rsp4.p.valid !== 1'b0) begin errors++; $display("FAIL rstflight_valid_l4 got %b exp 0", rsp4.p.valid); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 6; k++) begin
            idle(1);
            checks++;
            if (rsp4.p.valid !== 1'b0 || rsp1.p.valid !== 1'b0) begin errors++; $display("FAIL rstflight_drop k=%0d got %b%b exp 00", k, rsp1.p.valid, rsp4.p.valid); end
        end
        issue(1'b0, 48'h100, 64'd0, 8'd0);
        idle(3);
        checks++; if (rsp4.p.data !== bb_data[0]) begin errors++; $display("FAIL retain_data_l4 got %h exp %h", rsp4.p.data, bb_data[0]); end
    endtask

    task automatic test_random();
        bit acc, v, w;
        int word;
        logic [47:0] a;
        logic [7:0]  s;
        for (int n = 0; n < 300; n++) begin
            word = int'($urandom_range(0, 31));
            a = (48'($urandom_range(0, 3)) << 14) | (48'(word) << 3) | 48'($urandom_range(0, 7));
            v = ($urandom_range(0, 3) != 0);
            w = !written[word] || ($urandom_range(0, 1) == 1);
            s = written[word] ? 8'($urandom) : 8'hFF;
            step(v, w, a, {$urandom, $urandom}, s, acc);
            checks++;
            if (rsp1.p.valid !== exp_v(1) || (exp_v(1) && rsp1.p.data !== exp_d(1))) begin
                errors++; $display("FAIL rand_l1 n=%0d got %b/%h exp %b/%h", n, rsp1.p.valid, rsp1.p.data, exp_v(1), exp_d(1));
            end
            checks++;
            if (rsp4.p.valid !== exp_v(4) || (exp_v(4) && rsp4.p.data !== exp_d(4))) begin
                errors++; $display("FAIL rand_l4 n=%0d got %b/%h exp %b/%h", n, rsp4.p.valid, rsp4.p.data, exp_v(4), exp_d(4));
            end
            checks++;
            if (rsp1.q_ready !== ref_ready) begin errors++; $display("FAIL rand_ready n=%0d got %b exp %b", n, rsp1.q_ready, ref_ready); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_reset_inflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
